// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage feeding decode.
//
// Owns the program counter, issues one word fetch at a time to instruction
// memory (req/gnt/rvalid handshake), and hands one instruction per cycle to
// decode through a registered output backed by a one-entry skid buffer, so a
// decode stall never drops a returned word. Redirects flush all buffered work
// and restart fetch; a response still in flight at redirect time is discarded.
//
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   im_req/im_addr       fetch request and word address (out)
//   im_gnt               memory accepts request (in)
//   im_rvalid/im_rdata   in-order response (in)
//   id_stall             decode cannot accept this cycle (in)
//   redirect_valid/_pc   flush and restart fetch at redirect_pc (in)
//   if_valid, if_instruction, if_pc, if_pc_plus1   decode-side outputs
//
// Optional: define IF_PERF_CNT_EN to add perf_fetch_cnt / perf_stall_cnt.

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    output logic [31:0] if_pc_plus1
);

    localparam logic [1:0] StBoot  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;   // address of the outstanding request
    logic        kill_q, kill_d;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_pc1_q, out_pc1_d;

    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic issue;
    logic rsp;
    logic rsp_take;
    logic out_free;

    // Skid full blocks issue, which guarantees any returning word has a home.
    assign im_req   = (state_q == StFetch) && !skid_valid_q;
    assign im_addr  = pc_q;
    assign issue    = im_req && im_gnt;
    assign rsp      = (state_q == StWait) && im_rvalid;
    assign rsp_take = rsp && !kill_q && !redirect_valid;
    assign out_free = !out_valid_q || !id_stall;

    assign if_valid       = out_valid_q;
    assign if_instruction = out_instr_q;
    assign if_pc          = out_pc_q;
    assign if_pc_plus1    = out_pc1_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        kill_d       = kill_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        out_pc1_d    = out_pc1_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        case (state_q)
            StBoot: state_d = StFetch;
            StFetch: begin
                if (issue) begin
                    state_d  = StWait;
                    req_pc_d = pc_q;
                    pc_d     = pc_q + PC_STEP;
                end
            end
            StWait: begin
                if (rsp) begin
                    state_d = StFetch;
                    kill_d  = 1'b0;
                end
            end
            default: state_d = StBoot;
        endcase

        // Output register / skid buffer. Skid valid implies output valid, so
        // when the output frees up the skid entry always goes first.
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_instr_d  = skid_instr_q;
                out_pc_d     = skid_pc_q;
                out_pc1_d    = skid_pc_q + PC_STEP;
                skid_valid_d = rsp_take;
                if (rsp_take) begin
                    skid_instr_d = im_rdata;
                    skid_pc_d    = req_pc_q;
                end
            end else if (rsp_take) begin
                out_valid_d = 1'b1;
                out_instr_d = im_rdata;
                out_pc_d    = req_pc_q;
                out_pc1_d   = req_pc_q + PC_STEP;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (rsp_take) begin
            skid_valid_d = 1'b1;
            skid_instr_d = im_rdata;
            skid_pc_d    = req_pc_q;
        end

        // Redirect wins over everything. A request still in flight (waiting,
        // or granted this very cycle) must have its response discarded; a
        // response arriving this cycle is simply dropped.
        if (redirect_valid) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            pc_d         = redirect_pc;
            if (((state_q == StWait) && !im_rvalid) || issue) begin
                kill_d  = 1'b1;
                state_d = StWait;
            end else begin
                kill_d  = 1'b0;
                state_d = StFetch;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StBoot;
            pc_q         <= RESET_PC;
            req_pc_q     <= 32'd0;
            kill_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_instr_q  <= 32'd0;
            out_pc_q     <= 32'd0;
            out_pc1_q    <= 32'd0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'd0;
            skid_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            kill_q       <= kill_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            out_pc1_q    <= out_pc1_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (out_valid_q && !id_stall) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (out_valid_q && id_stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: stimulus pushes expected deliveries
// into a queue; a monitor pops and compares on every if_valid & !id_stall.
module tb_if_fetch_stage;

    logic        CLK;
    logic        RST;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus1;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    if_fetch_stage #(
        .RESET_PC(32'h0000_0100),
        .PC_STEP (32'd1)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .im_req        (im_req),
        .im_addr       (im_addr),
        .im_gnt        (im_gnt),
        .im_rvalid     (im_rvalid),
        .im_rdata      (im_rdata),
        .id_stall      (id_stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_instruction(if_instruction),
        .if_pc         (if_pc),
`ifdef IF_PERF_CNT_EN
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .if_pc_plus1   (if_pc_plus1)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc1;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;
    int   mem_lat;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] addr);
        exp_t e;
        e.instr = 32'hA000_0000 + addr;
        e.pc    = addr;
        e.pc1   = addr + 32'd1;
        exp_q.push_back(e);
    endtask

    // Memory model: grant sampled mid-cycle, word returned mem_lat cycles later.
    logic        mem_take;
    logic [31:0] mem_a;
    logic [31:0] mem_paddr;
    int          mem_cnt;
    initial begin
        im_rvalid = 1'b0;
        im_rdata  = 32'd0;
        mem_cnt   = 0;
        mem_paddr = 32'd0;
        forever begin
            @(negedge CLK);
            mem_take = im_req && im_gnt;
            mem_a    = im_addr;
            @(posedge CLK);
            #1;
            im_rvalid = 1'b0;
            if (RST) begin
                mem_cnt = 0;
            end else begin
                if (mem_take) begin
                    mem_cnt   = mem_lat;
                    mem_paddr = mem_a;
                end
                if (mem_cnt > 0) begin
                    mem_cnt--;
                    if (mem_cnt == 0) begin
                        im_rvalid = 1'b1;
                        im_rdata  = 32'hA000_0000 + mem_paddr;
                    end
                end
            end
        end
    end

    // Monitor: every delivery to decode is checked against the scoreboard.
    always @(negedge CLK) begin
        if (!RST && if_valid && !id_stall) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_delivery: got pc=%h instr=%h, queue empty",
                         if_pc, if_instruction);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (if_instruction !== e.instr || if_pc !== e.pc || if_pc_plus1 !== e.pc1) begin
                    bad++;
                    $display("FAIL delivery: got %h/%h/%h want %h/%h/%h", if_instruction,
                             if_pc, if_pc_plus1, e.instr, e.pc, e.pc1);
                end
            end
        end
    end

    task automatic do_reset(input bit check);
        @(posedge CLK);
        #1;
        RST            = 1'b1;
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        im_gnt         = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        if (check) begin
            chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
            chk("rst_if_instruction", if_instruction, 32'd0);
            chk("rst_if_pc", if_pc, 32'd0);
            chk("rst_if_pc_plus1", if_pc_plus1, 32'd0);
            chk("rst_im_req", {31'd0, im_req}, 32'd0);
        end
        exp_q.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic wait_req(input string name, input logic [31:0] addr);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!im_req && n < 30);
        chk(name, im_req ? im_addr : 32'hDEAD_DEAD, addr);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(posedge CLK);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d deliveries missing, want 0", name, exp_q.size());
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!if_valid && n < 30);
        chk(name, {31'd0, if_valid}, 32'd1);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        mem_lat        = 1;
        RST            = 1'b1;
        im_gnt         = 1'b1;
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        // Reset values, first fetch address, sequential stream.
        do_reset(1'b1);
        push_exp(32'h100);
        push_exp(32'h101);
        push_exp(32'h102);
        wait_req("first_im_addr", 32'h100);
        wait_req("second_im_addr", 32'h101);
        drain("stream_drain");

        // Stall while a response returns: output frozen, skid fills, no issue.
        do_reset(1'b0);
        push_exp(32'h100);
        push_exp(32'h101);
        push_exp(32'h102);
        push_exp(32'h103);
        begin
            int n;
            n = 0;
            do begin
                @(negedge CLK);
                n++;
            end while (!(if_valid && if_pc == 32'h100) && n < 30);
            chk("stall_pre_pc", if_pc, 32'h100);
        end
        @(posedge CLK);
        #1;
        id_stall = 1'b1;
        wait_valid("stall_valid");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge CLK);
            chk("stall_hold_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_hold_pc", if_pc, 32'h101);
            chk("stall_hold_instr", if_instruction, 32'hA000_0101);
        end
        chk("stall_no_issue", {31'd0, im_req}, 32'd0);
        @(posedge CLK);
        #1;
        id_stall = 1'b0;
        drain("stall_drain");

        // Redirect while waiting on a slow response: late word discarded.
        do_reset(1'b0);
        mem_lat = 3;
        push_exp(32'h100);
        wait_req("redir_pre_addr", 32'h100);
        wait_req("redir_pre_addr2", 32'h101);
        @(posedge CLK);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(posedge CLK);
        #1;
        redirect_valid = 1'b0;
        @(negedge CLK);
        chk("redir_wait_if_valid", {31'd0, if_valid}, 32'd0);
        chk("redir_wait_queue", exp_q.size(), 32'd0);
        exp_q.delete();
        push_exp(32'h200);
        wait_req("redir_wait_addr", 32'h200);
        drain("redir_wait_drain");

        // Redirect with decode stalled and skid full: both entries flushed.
        do_reset(1'b0);
        mem_lat  = 1;
        id_stall = 1'b1;
        repeat (10) @(negedge CLK);
        chk("skid_full_no_req", {31'd0, im_req}, 32'd0);
        chk("skid_full_pc", if_pc, 32'h100);
        push_exp(32'h300);
        push_exp(32'h301);
        @(posedge CLK);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        @(posedge CLK);
        #1;
        redirect_valid = 1'b0;
        id_stall       = 1'b0;
        @(negedge CLK);
        chk("redir_skid_if_valid", {31'd0, if_valid}, 32'd0);
        chk("redir_skid_im_req", {31'd0, im_req}, 32'd1);
        chk("redir_skid_im_addr", im_addr, 32'h300);
        drain("redir_skid_drain");

`ifdef IF_PERF_CNT_EN
        // 4 stall cycles then 3 deliveries; redirect + no grant stops the rest.
        do_reset(1'b0);
        chk("perf_rst_fetch", perf_fetch_cnt, 32'd0);
        chk("perf_rst_stall", perf_stall_cnt, 32'd0);
        id_stall = 1'b1;
        push_exp(32'h100);
        push_exp(32'h101);
        push_exp(32'h102);
        wait_valid("perf_valid");
        repeat (3) @(negedge CLK);
        @(posedge CLK);
        #1;
        id_stall = 1'b0;
        drain("perf_drain");
        #1;
        im_gnt         = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        @(posedge CLK);
        #1;
        redirect_valid = 1'b0;
        repeat (4) @(negedge CLK);
        chk("perf_fetch_cnt", perf_fetch_cnt, 32'd3);
        chk("perf_stall_cnt", perf_stall_cnt, 32'd4);
        do_reset(1'b0);
        @(negedge CLK);
        chk("perf_fetch_cnt_rst", perf_fetch_cnt, 32'd0);
        chk("perf_stall_cnt_rst", perf_stall_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage sitting directly upstream of the decode stage. It owns the program counter and issues word fetches to the instruction memory over a request/grant/response handshake. It buffers returned instructions so downstream stalls never drop data. It presents one instruction per cycle with its PC and PC+1 to decode, and accepts redirects (branch/jump) that flush in-flight work.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word address)
PC_STEP, 1, PC increment per sequential fetch (PC is a word address)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  synchronous reset, active-high
im_req  out  1  fetch request valid
im_addr  out  32  fetch word address, valid while im_req=1
im_gnt  in  1  memory accepts request this cycle (im_req & im_gnt = issue)
im_rvalid  in  1  response data valid (in order, ≥1 cycle after issue)
im_rdata  in  32  instruction word
id_stall  in  1  decode cannot accept; hold outputs
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  32  new fetch address
if_valid  out  1  if_instruction/if_pc valid
if_instruction  out  32  instruction to decode
if_pc  out  32  address of if_instruction
if_pc_plus1  out  32  if_pc + PC_STEP (link value for register-bank write)

Behaviour:
- Reset (RST=1 at edge): PC=RESET_PC, state=BOOT, if_valid=0, if_instruction=0, if_pc=0, if_pc_plus1=0, skid empty, kill=0, im_req=0. Reset mid-transaction discards any outstanding response (kill covers the first rvalid after reset is ignored only if it arrives in BOOT; BOOT never issues).
- States: BOOT -> FETCH (unconditional, one cycle). FETCH: im_req=1, im_addr=PC when skid empty; on im_gnt -> WAIT, PC<=PC+PC_STEP. WAIT: im_req=0; on im_rvalid -> FETCH.
- At most one outstanding request.
- Response handling: if kill=0, the word is written to the output register when the output is empty or consumed (if_valid=0 or id_stall=0), else to the one-entry skid buffer. Stored PC is the issued address.
- Consume: output advances when id_stall=0; skid entry (if any) moves to output first, in order.
- No issue while skid full; hence no data is ever dropped.
- Latency: issue to if_valid = response latency + 1 cycle (output is registered). Zero-wait memory sustains one instruction per 2 cycles.
- Redirect (highest priority, overrides id_stall): next cycle if_valid=0, skid emptied, PC=redirect_pc, state=FETCH. If a request is outstanding (state WAIT, or granted same cycle), set kill=1 and stay in/enter WAIT; the next im_rvalid is discarded and clears kill, then FETCH issues redirect_pc.
- Redirect coincident with im_rvalid: that response is discarded; kill not set.
- PC wrap: 32'hFFFF_FFFF + 1 = 0, no flag.
- Outputs stable while if_valid=1 and id_stall=1.

Optional Feature:
IF_PERF_CNT_EN: when defined, adds outputs perf_fetch_cnt[31:0] (count of instructions delivered to decode, i.e. if_valid & !id_stall) and perf_stall_cnt[31:0] (cycles with if_valid & id_stall). Both reset to 0, wrap at 2^32, and are unaffected by redirect. When undefined, the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=0x100, im_gnt=1, 1-cycle memory -> first im_addr=0x100; if_valid rises with if_pc=0x100 and if_pc_plus1=0x101; next fetch at 0x101.
- Sequential stream, memory returns 0xA0000000+addr -> if_instruction sequence 0xA0000100, 0xA0000101, 0xA0000102 in order with no gaps beyond the 2-cycle cadence.
- id_stall held 5 cycles while a response returns -> output frozen at 0x101; response goes to skid; no new issue; after release, 0x102 then 0x103 are delivered in order with none lost.
- redirect_valid to 0x200 while in WAIT -> next cycle if_valid=0; the late response is discarded; next im_addr=0x200; next delivered if_pc=0x200.
- redirect_valid with id_stall=1 and skid full -> both entries flushed; if_valid=0 next cycle; fetch resumes at redirect_pc.
- IF_PERF_CNT_EN defined: 3 delivered instructions and 4 stall cycles -> perf_fetch_cnt=3, perf_stall_cnt=4; RST returns both counters to 0.
